// File: rtl/seven_seg_display_driver.sv
// Four-digit multiplexed seven-segment driver: hex nibbles or sequential double-dabble decimal.
// Optional macro LEADING_ZERO_BLANK_EN blanks leading decimal zeros.
module seven_seg_display_driver #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int REFRESH_HZ = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] value,
    input  logic        display_is_hex,
    output logic [6:0]  seg,
    output logic        dp,
    output logic [3:0]  an,
    output logic        busy
);

    localparam int DIGIT_CYCLES = CLK_FREQ / (REFRESH_HZ * 4);
    localparam int DWELL_W      = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;

    localparam logic [4:0] CODE_DASH  = 5'd16;
    localparam logic [4:0] CODE_BLANK = 5'd17;

    typedef enum logic [1:0] {
        IDLE,
        CONV,
        LOAD
    } state_t;

    state_t        r_state;
    state_t        w_nextState;

    logic [15:0]   r_snapValue;
    logic          r_snapMode;
    logic [19:0]   r_bcd;
    logic [15:0]   r_shift;
    logic [3:0]    r_step;
    logic [4:0]    r_digit [4];

    logic [DWELL_W-1:0] r_dwell;
    logic [1:0]    r_scanIdx;

    logic          w_changed;
    logic          w_capture;
    logic          w_load;
    logic [15:0]   w_bcdAdj;
    logic [4:0]    w_loadDigit [4];

    function automatic logic [6:0] glyph(input logic [4:0] code);
        case (code)
            5'd0:    glyph = 7'h40;
            5'd1:    glyph = 7'h79;
            5'd2:    glyph = 7'h24;
            5'd3:    glyph = 7'h30;
            5'd4:    glyph = 7'h19;
            5'd5:    glyph = 7'h12;
            5'd6:    glyph = 7'h02;
            5'd7:    glyph = 7'h78;
            5'd8:    glyph = 7'h00;
            5'd9:    glyph = 7'h10;
            5'd10:   glyph = 7'h08;
            5'd11:   glyph = 7'h03;
            5'd12:   glyph = 7'h46;
            5'd13:   glyph = 7'h21;
            5'd14:   glyph = 7'h06;
            5'd15:   glyph = 7'h0E;
            5'd16:   glyph = 7'h3F;
            default: glyph = 7'h7F;
        endcase
    endfunction

    assign w_changed = (value != r_snapValue) || (display_is_hex != r_snapMode);

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (w_changed) w_nextState = display_is_hex ? LOAD : CONV;
            CONV:    if (r_step == 4'd15) w_nextState = LOAD;
            LOAD:    w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_comb begin
        busy      = (r_state == CONV);
        w_capture = (r_state == IDLE) && w_changed;
        w_load    = (r_state == LOAD);
    end

    // The ten-thousands nibble is at most 3 before any shift, so it never needs the +3 correction.
    always_comb begin
        w_bcdAdj = r_bcd[15:0];
        for (int i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) w_bcdAdj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
        end
    end

    always_comb begin
        for (int i = 0; i < 4; i++) w_loadDigit[i] = 5'd0;
        if (r_snapMode) begin
            for (int i = 0; i < 4; i++) w_loadDigit[i] = {1'b0, r_snapValue[4*i +: 4]};
        end else if (r_bcd[19:16] != 4'd0) begin
            for (int i = 0; i < 4; i++) w_loadDigit[i] = CODE_DASH;
        end else begin
            for (int i = 0; i < 4; i++) w_loadDigit[i] = {1'b0, r_bcd[4*i +: 4]};
`ifdef LEADING_ZERO_BLANK_EN
            if (r_bcd[15:12] == 4'd0) w_loadDigit[3] = CODE_BLANK;
            if (r_bcd[15:8]  == 8'd0) w_loadDigit[2] = CODE_BLANK;
            if (r_bcd[15:4]  == 12'd0) w_loadDigit[1] = CODE_BLANK;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_snapValue <= '0;
            r_snapMode  <= 1'b0;
            r_bcd       <= '0;
            r_shift     <= '0;
            r_step      <= '0;
            for (int i = 0; i < 4; i++) r_digit[i] <= 5'd0;
        end else begin
            if (w_capture) begin
                r_snapValue <= value;
                r_snapMode  <= display_is_hex;
                r_bcd       <= '0;
                r_shift     <= value;
                r_step      <= '0;
            end else if (busy) begin
                r_bcd   <= {r_bcd[18:16], w_bcdAdj, r_shift[15]};
                r_shift <= {r_shift[14:0], 1'b0};
                r_step  <= r_step + 4'd1;
            end
            if (w_load) begin
                for (int i = 0; i < 4; i++) r_digit[i] <= w_loadDigit[i];
            end
        end
    end

    // Outputs are registered from the scan index, so a swap shows one cycle after terminal count.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dwell   <= '0;
            r_scanIdx <= 2'd0;
            seg       <= 7'h7F;
            an        <= 4'b1111;
            dp        <= 1'b1;
        end else begin
            if (r_dwell == DWELL_W'(DIGIT_CYCLES - 1)) begin
                r_dwell   <= '0;
                r_scanIdx <= r_scanIdx + 2'd1;
            end else begin
                r_dwell <= r_dwell + 1'b1;
            end
            seg <= glyph(r_digit[r_scanIdx]);
            an  <= ~(4'b0001 << r_scanIdx);
            dp  <= ~((r_scanIdx == 2'd0) && r_snapMode);
        end
    end

endmodule

// File: tb/tb_seven_seg_display_driver.sv
// Testbench for seven_seg_display_driver: table vectors, corner sequences and a random sweep
// checked against an arithmetic model of the displayed digits.
module tb_seven_seg_display_driver;

    localparam int CLK_FREQ   = 400;
    localparam int REFRESH_HZ = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] value;
    logic        hex;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        busy;

    int vectors     = 0;
    int miscompares = 0;

    typedef struct {
        logic [15:0] value;
        logic        hex;
        logic [19:0] expCodes;
    } vec_t;

    vec_t tbl [11];

    always #5 clk = ~clk;

    seven_seg_display_driver #(
        .CLK_FREQ   (CLK_FREQ),
        .REFRESH_HZ (REFRESH_HZ)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .value          (value),
        .display_is_hex (hex),
        .seg            (seg),
        .dp             (dp),
        .an             (an),
        .busy           (busy)
    );

    function automatic logic [19:0] pk(input int d3, input int d2, input int d1, input int d0);
        return {5'(d3), 5'(d2), 5'(d1), 5'(d0)};
    endfunction

    function automatic logic [6:0] glyphOf(input logic [4:0] code);
        case (code)
            5'd0:    return 7'b1000000;
            5'd1:    return 7'b1111001;
            5'd2:    return 7'b0100100;
            5'd3:    return 7'b0110000;
            5'd4:    return 7'b0011001;
            5'd5:    return 7'b0010010;
            5'd6:    return 7'b0000010;
            5'd7:    return 7'b1111000;
            5'd8:    return 7'b0000000;
            5'd9:    return 7'b0010000;
            5'd10:   return 7'b0001000;
            5'd11:   return 7'b0000011;
            5'd12:   return 7'b1000110;
            5'd13:   return 7'b0100001;
            5'd14:   return 7'b0000110;
            5'd15:   return 7'b0001110;
            5'd16:   return 7'b0111111;
            default: return 7'b1111111;
        endcase
    endfunction

    function automatic logic [19:0] modelDigits(input logic [15:0] v, input logic h);
        int n;
        int d [4];
        n = int'(v);
        if (h) begin
            for (int i = 0; i < 4; i++) d[i] = (n >> (4 * i)) & 15;
        end else if (n > 9999) begin
            for (int i = 0; i < 4; i++) d[i] = 16;
        end else begin
            d[0] = n % 10;
            d[1] = (n / 10) % 10;
            d[2] = (n / 100) % 10;
            d[3] = n / 1000;
`ifdef LEADING_ZERO_BLANK_EN
            if (n < 1000) d[3] = 17;
            if (n < 100)  d[2] = 17;
            if (n < 10)   d[1] = 17;
`endif
        end
        return pk(d[3], d[2], d[1], d[0]);
    endfunction

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        vectors++;
        if (actual !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h, required %0h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] v, input logic h);
        @(negedge clk);
        value = v;
        hex   = h;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Walk one full scan and compare each selected digit's segments and decimal point.
    task automatic checkOutput(input string name, input logic [19:0] codes, input logic h);
        logic [3:0] target;
        logic [6:0] expSeg;
        logic       expDp;
        int         n;
        for (int k = 0; k < 4; k++) begin
            target = ~(4'b0001 << k);
            n = 0;
            while (an !== target && n < 200) begin
                @(negedge clk);
                n++;
            end
            vectors++;
            if (an !== target) begin
                miscompares++;
                $display("[TB] FAIL %s digit%0d: an stuck at %b, required %b", name, k, an, target);
            end else begin
                expSeg = glyphOf(codes[5*k +: 5]);
                expDp  = !(k == 0 && h);
                if ({seg, dp} !== {expSeg, expDp}) begin
                    miscompares++;
                    $display("[TB] FAIL %s digit%0d: seg=%b dp=%b, required seg=%b dp=%b",
                             name, k, seg, dp, expSeg, expDp);
                end
            end
        end
    endtask

    initial begin
        int busyCycles;
        int rises;
        logic prevBusy;
        int n;
        logic [15:0] rv;
        logic rh;

        reset = 1'b1;
        value = 16'h0000;
        hex   = 1'b0;
        waitCycles(3);
        check("resetAn",   32'(an),   32'h0000_000F);
        check("resetSeg",  32'(seg),  32'h0000_007F);
        check("resetDp",   32'(dp),   32'h1);
        check("resetBusy", 32'(busy), 32'h0);
        reset = 1'b0;
        waitCycles(2);
        checkOutput("postReset0000", pk(0, 0, 0, 0), 1'b0);

        tbl[0]  = '{16'h1234, 1'b0, pk(4, 6, 6, 0)};
        tbl[1]  = '{16'hFFFF, 1'b1, pk(15, 15, 15, 15)};
        tbl[2]  = '{16'h270F, 1'b0, pk(9, 9, 9, 9)};
        tbl[3]  = '{16'h2710, 1'b0, pk(16, 16, 16, 16)};
        tbl[4]  = '{16'hFFFF, 1'b0, pk(16, 16, 16, 16)};
        tbl[5]  = '{16'h00A5, 1'b1, pk(0, 0, 10, 5)};
`ifdef LEADING_ZERO_BLANK_EN
        tbl[6]  = '{16'h00A5, 1'b0, pk(17, 1, 6, 5)};
        tbl[7]  = '{16'h0007, 1'b0, pk(17, 17, 17, 7)};
        tbl[8]  = '{16'h0000, 1'b0, pk(17, 17, 17, 0)};
        tbl[10] = '{16'h0000, 1'b0, pk(17, 17, 17, 0)};
`else
        tbl[6]  = '{16'h00A5, 1'b0, pk(0, 1, 6, 5)};
        tbl[7]  = '{16'h0007, 1'b0, pk(0, 0, 0, 7)};
        tbl[8]  = '{16'h0000, 1'b0, pk(0, 0, 0, 0)};
        tbl[10] = '{16'h0000, 1'b0, pk(0, 0, 0, 0)};
`endif
        tbl[9]  = '{16'h0000, 1'b1, pk(0, 0, 0, 0)};

        for (int i = 0; i < 11; i++) begin
            applyStimulus(tbl[i].value, tbl[i].hex);
            waitCycles(40);
            checkOutput($sformatf("table%0d", i), tbl[i].expCodes, tbl[i].hex);
        end

        // Decimal conversion keeps busy high for exactly 16 cycles; hex never raises it.
        applyStimulus(16'h1234, 1'b0);
        busyCycles = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busyCycles++;
        end
        check("busyWidthDec", 32'(busyCycles), 32'd16);
        applyStimulus(16'hFFFF, 1'b1);
        busyCycles = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (busy) busyCycles++;
        end
        check("busyWidthHex", 32'(busyCycles), 32'd0);
        checkOutput("hexFFFF", pk(15, 15, 15, 15), 1'b1);

        // Value change mid-conversion forces a second conversion to the final value.
        applyStimulus(16'h0001, 1'b0);
        rises = 0;
        prevBusy = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (i == 4) value = 16'h0064;
            if (busy && !prevBusy) rises++;
            prevBusy = busy;
        end
        check("reconvertCount", 32'(rises), 32'd2);
        checkOutput("reconvert100", modelDigits(16'h0064, 1'b0), 1'b0);

        // Randomized sweep, biased toward the 9999/10000 boundary.
        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) rv = 16'($urandom_range(9990, 10010));
            else                           rv = 16'($urandom_range(0, 65535));
            rh = 1'($urandom_range(0, 1));
            applyStimulus(rv, rh);
            waitCycles(40);
            checkOutput($sformatf("rand%0d_%0h_%0d", i, rv, rh), modelDigits(rv, rh), rh);
        end

        // Reset at conversion step 8 aborts everything.
        applyStimulus(16'h1235, 1'b0);
        n = 0;
        while (!busy && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("midConvBusySeen", 32'(busy), 32'h1);
        waitCycles(8);
        reset = 1'b1;
        @(negedge clk);
        check("midResetAn",   32'(an),   32'h0000_000F);
        check("midResetSeg",  32'(seg),  32'h0000_007F);
        check("midResetDp",   32'(dp),   32'h1);
        check("midResetBusy", 32'(busy), 32'h0);
        reset = 1'b0;
        value = 16'h0000;
        hex   = 1'b0;
        busyCycles = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) busyCycles++;
        end
        check("noConvAfterReset", 32'(busyCycles), 32'd0);
        checkOutput("afterReset0000", pk(0, 0, 0, 0), 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
